uart_cmd_responder: RTL

Byte-level command responder on the far side of the UART link: consumes received bytes from the UART controller's receive interface, decodes read and write commands from a remote initiator, and returns one reply byte per command through the controller's transmit interface. Holds a small 8-bit register file that the initiator reads and writes. Sits directly beside the UART controller: its receive outputs drive `rx_*`, and the controller's transmit inputs are driven by `tx_*`.

---
 rtl/uart_rsp_pkg.sv | 17 +
 rtl/uart_rsp_regfile.sv | 34 +++
 rtl/uart_cmd_responder.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/uart_rsp_pkg.sv
// Shared constants for the UART command responder: opcodes, reply bytes and FSM encoding.
package uart_rsp_pkg;

  localparam logic [7:0] OpWrite = 8'h57;
  localparam logic [7:0] OpRead  = 8'h52;
  localparam logic [7:0] RspOk   = 8'h4B;
  localparam logic [7:0] RspErr  = 8'h3F;

  typedef enum logic [2:0] {
    StIdle,
    StGetAddr,
    StGetData,
    StTxSend,
    StTxWait
  } state_e;

endpackage

// File: rtl/uart_rsp_regfile.sv
// Byte register file: one synchronous write port, combinational read, flattened view of all bytes.
module uart_rsp_regfile #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we,
  input  logic [ADDR_W-1:0]           waddr,
  input  logic [7:0]                  wdata,
  input  logic [ADDR_W-1:0]           raddr,
  output logic [7:0]                  rdata,
  output logic [8*(2**ADDR_W)-1:0]    regs
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [7:0] mem [Depth];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < Depth; k++) mem[k] <= 8'h00;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

  always_comb begin
    regs = '0;
    for (int k = 0; k < Depth; k++) regs[8*k +: 8] = mem[k];
  end

endmodule

// File: rtl/uart_cmd_responder.sv
// Decodes W/R byte commands from the UART receive side and returns one reply byte per command.
// Optional inter-byte timeout is enabled by defining UART_RSP_TIMEOUT_EN.
module uart_cmd_responder
  import uart_rsp_pkg::*;
#(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  input  logic                     tx_rdy,
  output logic [7:0]               tx_data,
  output logic                     tx_en,
  output logic [8*(2**ADDR_W)-1:0] regs,
  output logic                     ovr
);

  state_e            state_q;
  logic              is_write_q;
  logic              addr_ok_q;
  logic              guard_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        reply_q;
  logic [7:0]        rd_data;
  logic              rx_addr_ok;
  logic              we;
  logic              timeout;

  // Address bytes with any bit set above the register range are rejected.
  assign rx_addr_ok = (32'(rx_data) >> ADDR_W) == 32'd0;
  assign we         = (state_q == StGetData) && rx_valid && addr_ok_q;

  uart_rsp_regfile #(
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (addr_q),
    .wdata (rx_data),
    .raddr (rx_data[ADDR_W-1:0]),
    .rdata (rd_data),
    .regs  (regs)
  );

`ifdef UART_RSP_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC) + 1;

  logic [CntW-1:0] cnt_q;
  logic            waiting;

  assign waiting = (state_q == StGetAddr) || (state_q == StGetData);
  // A byte arriving on the expiry cycle takes priority over the timeout.
  assign timeout = waiting && !rx_valid && (cnt_q == CntW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (waiting && !rx_valid && !timeout) begin
      cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      is_write_q <= 1'b0;
      addr_ok_q  <= 1'b0;
      guard_q    <= 1'b0;
      addr_q     <= '0;
      reply_q    <= 8'h00;
      tx_data    <= 8'h00;
      tx_en      <= 1'b0;
      ovr        <= 1'b0;
    end else begin
      tx_en <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (rx_valid) begin
            if (rx_data == OpWrite || rx_data == OpRead) begin
              is_write_q <= (rx_data == OpWrite);
              state_q    <= StGetAddr;
            end else begin
              reply_q <= RspErr;
              state_q <= StTxSend;
            end
          end
        end
        StGetAddr: begin
          if (rx_valid) begin
            addr_q    <= rx_data[ADDR_W-1:0];
            addr_ok_q <= rx_addr_ok;
            if (is_write_q) begin
              state_q <= StGetData;
            end else begin
              // Latch the read value now so a later write cannot change the reply.
              reply_q <= rx_addr_ok ? rd_data : RspErr;
              state_q <= StTxSend;
            end
          end else if (timeout) begin
            state_q <= StIdle;
          end
        end
        StGetData: begin
          if (rx_valid) begin
            reply_q <= addr_ok_q ? RspOk : RspErr;
            state_q <= StTxSend;
          end else if (timeout) begin
            state_q <= StIdle;
          end
        end
        StTxSend: begin
          if (rx_valid) ovr <= 1'b1;
          if (tx_rdy) begin
            tx_en   <= 1'b1;
            tx_data <= reply_q;
            guard_q <= 1'b1;
            state_q <= StTxWait;
          end
        end
        StTxWait: begin
          if (rx_valid) ovr <= 1'b1;
          // tx_rdy may still read high on the cycle right after tx_en.
          if (guard_q) begin
            guard_q <= 1'b0;
          end else if (tx_rdy) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
